// File: rtl/lin_pkg.sv
// Shared definitions for the LIN responder: state encoding, slot counts,
// header error codes and the PID parity helper.
package lin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_CHECK,
        ST_GAP,
        ST_TX,
        ST_DONE
    } resp_state_t;

    localparam int SYNC_SLOTS = 10;
    localparam int PID_SLOTS  = 11;
    localparam int BYTE_SLOTS = 10;

    localparam logic [1:0] ERR_SYNC   = 2'b01;
    localparam logic [1:0] ERR_PARITY = 2'b10;

    // Returns {p1, p0} for a 6-bit frame identifier.
    function automatic logic [1:0] lin_parity(input logic [5:0] id);
        lin_parity = {id[1] ^ id[3] ^ id[4] ^ id[5],
                      id[0] ^ id[1] ^ id[2] ^ id[4]};
    endfunction

endpackage

// File: rtl/lin_checksum.sv
// LIN checksum accumulator: 8-bit add with end-around carry, output inverted.
// clr has priority over seed_en, which has priority over add_en.
module lin_checksum (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       seed_en,
    input  logic [7:0] seed,
    input  logic       add_en,
    input  logic [7:0] add_byte,
    output logic [7:0] chk
);

    logic [7:0] sum;
    logic [8:0] s_add;

    // A carry out of bit 7 is folded back into bit 0; the fold cannot overflow again.
    assign s_add = {1'b0, sum} + {1'b0, add_byte};
    assign chk   = ~sum;

    // Accumulator register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (seed_en) begin
            sum <= seed;
        end else if (add_en) begin
            sum <= s_add[7:0] + {7'd0, s_add[8]};
        end
    end

endmodule

// File: rtl/lin_resp.sv
// LIN responder: hunts for break + delimiter, checks sync and PID, then sends
// NUM_BYTES data bytes and a checksum, holding resp_busy for the commander.
// Define LIN_ENHANCED_CHECKSUM_EN to seed the checksum with the protected PID.
// Handshake: resp_busy rises after an accepted PID check with resp_en high and
// falls in the cycle resp_tx_done pulses; the commander waits for the fall.
module lin_resp
    import lin_pkg::*;
#(
    parameter int NUM_BYTES = 2,
    parameter int BREAK_MIN = 13,
    parameter int RESP_GAP  = 2
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   sdi_resp,
    input  logic                   resp_en,
    input  logic [8*NUM_BYTES-1:0] resp_data,
    output logic                   sdo_resp,
    output logic                   resp_busy,
    output logic [5:0]             pid_out,
    output logic                   pid_valid,
    output logic                   hdr_err,
    output logic [1:0]             err_code,
    output logic                   resp_tx_done
);

    localparam int LW = $clog2(BREAK_MIN + 1);
    localparam int GW = $clog2(RESP_GAP + 1);
    localparam logic [LW-1:0] BRK_MAX   = LW'(BREAK_MIN);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(RESP_GAP - 1);
    localparam logic [3:0]    LAST_BYTE = 4'(NUM_BYTES);
    localparam logic [3:0]    SYNC_END  = 4'(SYNC_SLOTS - 1);
    localparam logic [3:0]    PID_END   = 4'(PID_SLOTS - 1);
    localparam logic [3:0]    BYTE_END  = 4'(BYTE_SLOTS - 1);

    resp_state_t            state, next_state;
    logic [LW-1:0]          low_cnt;
    logic [3:0]             slot_cnt;
    logic [3:0]             byte_idx;
    logic [GW-1:0]          gap_cnt;
    logic [5:0]             hdr_id;
    logic [1:0]             hdr_par;
    logic [8*NUM_BYTES-1:0] data_sr;
    logic                   pid_bad;
    logic                   par_ok;
    logic                   sync_err;
    logic                   start_resp;
    logic                   tx_last;
    logic [7:0]             chk;
    logic [7:0]             tx_byte;
    logic [7:0]             seed;
    logic [2:0]             bit_idx;

    assign par_ok     = (lin_parity(hdr_id) == hdr_par);
    assign start_resp = (state == ST_CHECK) && par_ok && resp_en;
    assign tx_last    = (state == ST_TX) && (slot_cnt == BYTE_END) && (byte_idx == LAST_BYTE);
    assign tx_byte    = (byte_idx == LAST_BYTE) ? chk : data_sr[7:0];
    assign bit_idx    = 3'(slot_cnt - 4'd1);

`ifdef LIN_ENHANCED_CHECKSUM_EN
    assign seed = {lin_parity(hdr_id), hdr_id};
`else
    assign seed = 8'h00;
`endif

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and header slot checks.
    always_comb begin
        next_state = state;
        pid_bad    = 1'b0;
        sync_err   = 1'b0;
        case (slot_cnt)
            4'd0:    pid_bad = sdi_resp;
            4'd7:    pid_bad = (sdi_resp != hdr_id[5]);
            4'd10:   pid_bad = !sdi_resp;
            default: pid_bad = 1'b0;
        endcase
        case (state)
            ST_IDLE: begin
                if (sdi_resp && (low_cnt == BRK_MAX)) next_state = ST_SYNC;
            end
            ST_SYNC: begin
                if (sdi_resp != slot_cnt[0]) begin
                    sync_err   = 1'b1;
                    next_state = ST_IDLE;
                end else if (slot_cnt == SYNC_END) begin
                    next_state = ST_PID;
                end
            end
            ST_PID: begin
                if (pid_bad) begin
                    sync_err   = 1'b1;
                    next_state = ST_IDLE;
                end else if (slot_cnt == PID_END) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (start_resp) next_state = (RESP_GAP == 1) ? ST_TX : ST_GAP;
                else            next_state = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt <= GW'(1)) next_state = ST_TX;
            end
            ST_TX: begin
                if (tx_last) next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Counters, header capture, payload shifter and registered outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            low_cnt      <= '0;
            slot_cnt     <= 4'd0;
            byte_idx     <= 4'd0;
            gap_cnt      <= '0;
            hdr_id       <= 6'd0;
            hdr_par      <= 2'd0;
            data_sr      <= '0;
            pid_out      <= 6'd0;
            pid_valid    <= 1'b0;
            hdr_err      <= 1'b0;
            err_code     <= 2'b00;
            resp_busy    <= 1'b0;
            resp_tx_done <= 1'b0;
        end else begin
            pid_valid    <= 1'b0;
            hdr_err      <= 1'b0;
            resp_tx_done <= tx_last;

            if (state == ST_IDLE) begin
                if (sdi_resp)                low_cnt <= '0;
                else if (low_cnt != BRK_MAX) low_cnt <= low_cnt + LW'(1);
            end else begin
                low_cnt <= '0;
            end

            if (state != next_state) begin
                slot_cnt <= 4'd0;
            end else if (state == ST_TX && slot_cnt == BYTE_END) begin
                slot_cnt <= 4'd0;
                byte_idx <= byte_idx + 4'd1;
                data_sr  <= data_sr >> 8;
            end else if (state == ST_SYNC || state == ST_PID || state == ST_TX) begin
                slot_cnt <= slot_cnt + 4'd1;
            end

            if (state == ST_PID) begin
                if (slot_cnt >= 4'd1 && slot_cnt <= 4'd6) hdr_id <= {sdi_resp, hdr_id[5:1]};
                if (slot_cnt == 4'd8) hdr_par[0] <= sdi_resp;
                if (slot_cnt == 4'd9) hdr_par[1] <= sdi_resp;
            end

            if (sync_err) begin
                hdr_err  <= 1'b1;
                err_code <= ERR_SYNC;
            end

            if (state == ST_CHECK) begin
                byte_idx <= 4'd0;
                gap_cnt  <= GAP_LOAD;
                if (!par_ok) begin
                    hdr_err  <= 1'b1;
                    err_code <= ERR_PARITY;
                end else begin
                    pid_valid <= 1'b1;
                    pid_out   <= hdr_id;
                end
            end

            if (state == ST_GAP) gap_cnt <= gap_cnt - GW'(1);

            if (start_resp) begin
                data_sr   <= resp_data;
                resp_busy <= 1'b1;
            end else if (tx_last) begin
                resp_busy <= 1'b0;
            end
        end
    end

    // Serial output: start 0, eight data bits LSB first, stop 1; idle high.
    always_comb begin
        sdo_resp = 1'b1;
        if (state == ST_TX) begin
            if (slot_cnt == 4'd0)          sdo_resp = 1'b0;
            else if (slot_cnt == BYTE_END) sdo_resp = 1'b1;
            else                           sdo_resp = tx_byte[bit_idx];
        end
    end

    lin_checksum u_checksum (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .clr      (state == ST_IDLE),
        .seed_en  (state == ST_CHECK),
        .seed     (seed),
        .add_en   ((state == ST_TX) && (slot_cnt == 4'd0) && (byte_idx != LAST_BYTE)),
        .add_byte (data_sr[7:0]),
        .chk      (chk)
    );

endmodule

// File: tb/tb_lin_resp.sv
// Directed bench for lin_resp: header encoder, response capture, table of
// header/response vectors and hand-written reset/short-break sequences.
module tb_lin_resp;

    localparam int NUM_BYTES = 2;
    localparam int RESP_GAP  = 2;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        sdi_resp;
    logic        resp_en;
    logic [15:0] resp_data;
    logic        sdo_resp;
    logic        resp_busy;
    logic [5:0]  pid_out;
    logic        pid_valid;
    logic        hdr_err;
    logic [1:0]  err_code;
    logic        resp_tx_done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pv    = 0;
    int n_he    = 0;
    int n_done  = 0;
    int n_busy  = 0;
    int n_low   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        string       name;
        int          brk;
        logic [5:0]  id;
        int          flip;
        logic        kill_p1;
        logic        en;
        logic [15:0] data;
        logic        exp_valid;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [7:0]  chk_classic;
        logic [7:0]  chk_enh;
    } vec_t;

    vec_t vecs[7];

    // Clock and reset generation.
    always #5 sys_clk = ~sys_clk;

    lin_resp #(.NUM_BYTES(NUM_BYTES), .BREAK_MIN(13), .RESP_GAP(RESP_GAP)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .sdi_resp     (sdi_resp),
        .resp_en      (resp_en),
        .resp_data    (resp_data),
        .sdo_resp     (sdo_resp),
        .resp_busy    (resp_busy),
        .pid_out      (pid_out),
        .pid_valid    (pid_valid),
        .hdr_err      (hdr_err),
        .err_code     (err_code),
        .resp_tx_done (resp_tx_done)
    );

    // Event monitor sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (pid_valid)    n_pv++;
            if (hdr_err)      n_he++;
            if (resp_tx_done) n_done++;
            if (resp_busy)    n_busy++;
            if (!sdo_resp)    n_low++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge sys_clk);
        sdi_resp = b;
    endtask

    // Break, delimiter, sync and PID; optional sync-slot flip and p1 kill.
    task automatic send_header(input int brk, input logic [5:0] id, input int flip, input logic kill_p1);
        logic p0, p1, b;
        p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
        p1 = id[1] ^ id[3] ^ id[4] ^ id[5];
        for (int i = 0; i < brk; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        for (int i = 0; i < 10; i++) begin
            b = (i % 2 == 1);
            if (i == flip) b = ~b;
            drive_bit(b);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 6; i++) drive_bit(id[i]);
        drive_bit(id[5]);
        drive_bit(p0);
        drive_bit(kill_p1 ? 1'b0 : p1);
        drive_bit(1'b1);
        drive_bit(1'b0);
    endtask

    // Measures start-bit latency, then deserialises and scores all bytes.
    task automatic capture_resp(input string name, input logic [15:0] data, input logic [7:0] chk);
        int cnt;
        logic [7:0] got;
        logic [7:0] exp;
        exp_q.push_back(data[7:0]);
        exp_q.push_back(data[15:8]);
        exp_q.push_back(chk);
        cnt = 0;
        while (sdo_resp !== 1'b0 && cnt < 20) begin
            @(negedge sys_clk);
            cnt++;
        end
        check({name, " latency"}, cnt, RESP_GAP);
        if (cnt >= 20) begin
            exp_q.delete();
            return;
        end
        check({name, " busy at start"}, resp_busy, 1'b1);
        for (int b = 0; b <= NUM_BYTES; b++) begin
            if (b > 0) @(negedge sys_clk);
            check($sformatf("%s start%0d", name, b), sdo_resp, 1'b0);
            for (int k = 0; k < 8; k++) begin
                @(negedge sys_clk);
                got[k] = sdo_resp;
            end
            @(negedge sys_clk);
            check($sformatf("%s stop%0d", name, b), sdo_resp, 1'b1);
            exp = exp_q.pop_front();
            check($sformatf("%s byte%0d", name, b), got, exp);
        end
        @(negedge sys_clk);
        check({name, " busy drop"}, resp_busy, 1'b0);
        check({name, " tx_done"}, resp_tx_done, 1'b1);
        @(negedge sys_clk);
        check({name, " tx_done pulse"}, resp_tx_done, 1'b0);
    endtask

    initial begin
        int pv0, he0, dn0, bz0, lo0;
        logic [7:0] chk;

        vecs[0] = '{"basic",   13, 6'h2A, -1, 1'b0, 1'b1, 16'h2211, 1'b1, 1'b0, 2'b00, 8'hCC, 8'hE1};
        vecs[1] = '{"parity",  13, 6'h2A, -1, 1'b1, 1'b1, 16'h2211, 1'b0, 1'b1, 2'b10, 8'h00, 8'h00};
        vecs[2] = '{"syncflip",13, 6'h2A,  4, 1'b0, 1'b1, 16'h2211, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00};
        vecs[3] = '{"wrap",    13, 6'h2A, -1, 1'b0, 1'b1, 16'h01FF, 1'b1, 1'b0, 2'b00, 8'hFE, 8'h14};
        vecs[4] = '{"id3c",    20, 6'h3C, -1, 1'b0, 1'b1, 16'hA55A, 1'b1, 1'b0, 2'b00, 8'h00, 8'h43};
        vecs[5] = '{"noen",    13, 6'h2A, -1, 1'b0, 1'b0, 16'h2211, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00};
        vecs[6] = '{"id00",    13, 6'h00, -1, 1'b0, 1'b1, 16'h8080, 1'b1, 1'b0, 2'b00, 8'hFE, 8'hFE};

        rst       = 1'b1;
        sdi_resp  = 1'b0;
        resp_en   = 1'b0;
        resp_data = 16'h0000;
        repeat (3) @(negedge sys_clk);
        check("rst sdo", sdo_resp, 1'b1);
        check("rst busy", resp_busy, 1'b0);
        check("rst pid_out", pid_out, 6'd0);
        check("rst pid_valid", pid_valid, 1'b0);
        check("rst hdr_err", hdr_err, 1'b0);
        check("rst err_code", err_code, 2'b00);
        check("rst tx_done", resp_tx_done, 1'b0);

        // Short break: a high clears the run, then only 12 lows before the delimiter.
        rst       = 1'b0;
        sdi_resp  = 1'b1;
        resp_en   = 1'b1;
        resp_data = 16'h2211;
        pv0 = n_pv; he0 = n_he; lo0 = n_low;
        send_header(12, 6'h2A, -1, 1'b0);
        repeat (30) @(negedge sys_clk);
        check("short pid_valid", n_pv - pv0, 0);
        check("short hdr_err", n_he - he0, 0);
        check("short sdo low", n_low - lo0, 0);

        foreach (vecs[i]) begin
`ifdef LIN_ENHANCED_CHECKSUM_EN
            chk = vecs[i].chk_enh;
`else
            chk = vecs[i].chk_classic;
`endif
            pv0 = n_pv; he0 = n_he; dn0 = n_done; bz0 = n_busy; lo0 = n_low;
            resp_en   = vecs[i].en;
            resp_data = vecs[i].data;
            send_header(vecs[i].brk, vecs[i].id, vecs[i].flip, vecs[i].kill_p1);
            if (vecs[i].exp_valid && vecs[i].en) capture_resp(vecs[i].name, vecs[i].data, chk);
            else repeat (30) @(negedge sys_clk);
            repeat (4) @(negedge sys_clk);
            check({vecs[i].name, " pid_valid"}, n_pv - pv0, {31'd0, vecs[i].exp_valid});
            check({vecs[i].name, " hdr_err"}, n_he - he0, {31'd0, vecs[i].exp_err});
            check({vecs[i].name, " tx_done cnt"}, n_done - dn0, {31'd0, vecs[i].exp_valid & vecs[i].en});
            if (vecs[i].exp_err) check({vecs[i].name, " err_code"}, err_code, vecs[i].exp_code);
            if (vecs[i].exp_valid) check({vecs[i].name, " pid_out"}, pid_out, vecs[i].id);
            if (!(vecs[i].exp_valid && vecs[i].en)) begin
                check({vecs[i].name, " no busy"}, n_busy - bz0, 0);
                check({vecs[i].name, " no tx"}, n_low - lo0, 0);
            end
        end

        // Reset in the middle of byte1 abandons the response.
        resp_en   = 1'b1;
        resp_data = 16'h2211;
        dn0 = n_done;
        send_header(13, 6'h2A, -1, 1'b0);
        repeat (RESP_GAP + 10 + 4) @(negedge sys_clk);
        check("midtx busy before rst", resp_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midtx rst sdo", sdo_resp, 1'b1);
        check("midtx rst busy", resp_busy, 1'b0);
        check("midtx rst pid_out", pid_out, 6'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("midtx no done", n_done - dn0, 0);
`ifdef LIN_ENHANCED_CHECKSUM_EN
        chk = 8'hE1;
`else
        chk = 8'hCC;
`endif
        send_header(13, 6'h2A, -1, 1'b0);
        capture_resp("after rst", 16'h2211, chk);
        check("after rst pid_out", pid_out, 6'h2A);

        repeat (5) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
